// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle RV32I-subset datapath (lw, sw, beq, add/sub/and/or).
// Outputs are state-decoded; memory waits are bounded by a watchdog that traps on timeout.
module multicycle_control #(
  parameter int RETIRE_W = 32,
  parameter int TIMEOUT  = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [6:0]          opcode,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                mem_we,
  output logic                iord,
  output logic                ir_write,
  output logic                pc_write,
  output logic                pc_src,
  output logic [1:0]          alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic                reg_write,
  output logic                mem_to_reg,
  output logic                illegal,
  output logic                bus_err,
  output logic [RETIRE_W-1:0] retired,
  output logic [3:0]          state_o
);

  localparam int WCW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  typedef enum logic [3:0] {
    S_INIT      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_EXEC_R    = 4'd7,
    S_R_WB      = 4'd8,
    S_BRANCH    = 4'd9,
    S_TRAP      = 4'd15
  } state_t;

  state_t              state_q, state_d;
  logic [6:0]          op_q, op_d;
  logic [WCW-1:0]      wait_q, wait_d;
  logic [RETIRE_W-1:0] retired_q, retired_d;
  logic                illegal_q, illegal_d;
  logic                bus_err_q, bus_err_d;
  logic                wait_state;
  logic                timeout_hit;
  logic                retire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_INIT;
      op_q      <= '0;
      wait_q    <= '0;
      retired_q <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  // The counter holds stalls already seen, so the current stall is wait_q+1;
  // a ready in that same cycle still completes the access.
  always_comb begin
    wait_state  = (state_q == S_FETCH) || (state_q == S_MEM_READ) || (state_q == S_MEM_WRITE);
    timeout_hit = (TIMEOUT > 0) && wait_state && !mem_ready &&
                  (wait_q == WCW'(TIMEOUT - 1));
    wait_d      = (wait_state && !mem_ready) ? wait_q + 1'b1 : '0;
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    illegal_d  = illegal_q;
    bus_err_d  = bus_err_q;
    retire     = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;

    case (state_q)
      S_INIT: state_d = S_FETCH;
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) state_d = S_DECODE;
        else if (timeout_hit) begin
          state_d   = S_TRAP;
          bus_err_d = 1'b1;
        end
      end
      S_DECODE: begin
        // ALUOut <= oldPC + imm: branch target ready before BRANCH
        alu_src_a = 2'b10;
        alu_src_b = 2'b10;
        op_d      = opcode;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_R:         state_d = S_EXEC_R;
          OP_BEQ:       state_d = S_BRANCH;
          default: begin
            state_d   = S_TRAP;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        state_d   = (op_q == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) state_d = S_MEM_WB;
        else if (timeout_hit) begin
          state_d   = S_TRAP;
          bus_err_d = 1'b1;
        end
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = S_FETCH;
        retire     = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
        if (mem_ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end else if (timeout_hit) begin
          state_d   = S_TRAP;
          bus_err_d = 1'b1;
        end
      end
      S_EXEC_R: begin
        alu_src_a = 2'b01;
        alu_op    = 2'b10;
        state_d   = S_R_WB;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
        retire    = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 2'b01;
        alu_op    = 2'b01;
        pc_src    = 1'b1;
        pc_write  = zero;
        state_d   = S_FETCH;
        retire    = 1'b1;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase

    retired_d = retire ? retired_q + RETIRE_W'(1) : retired_q;
  end

  assign illegal = illegal_q;
  assign bus_err = bus_err_q;
  assign retired = retired_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench: each instruction is expanded into its expected per-cycle trace
// (state, control outputs, inputs to drive) and compared cycle by cycle.
module tb_multicycle_control;
  localparam int T  = 4;
  localparam int RW = 4;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  // {mem_req, mem_we, iord, ir_write, pc_write, pc_src, src_a, src_b, alu_op, reg_write, mem_to_reg}
  localparam logic [13:0] O_NONE = 14'b0_0_0_0_0_0_00_00_00_0_0;
  localparam logic [13:0] O_FST  = 14'b1_0_0_0_0_0_00_01_00_0_0;
  localparam logic [13:0] O_FDN  = 14'b1_0_0_1_1_0_00_01_00_0_0;
  localparam logic [13:0] O_DEC  = 14'b0_0_0_0_0_0_10_10_00_0_0;
  localparam logic [13:0] O_MADR = 14'b0_0_0_0_0_0_01_10_00_0_0;
  localparam logic [13:0] O_MRD  = 14'b1_0_1_0_0_0_00_00_00_0_0;
  localparam logic [13:0] O_MWB  = 14'b0_0_0_0_0_0_00_00_00_1_1;
  localparam logic [13:0] O_MWR  = 14'b1_1_1_0_0_0_00_00_00_0_0;
  localparam logic [13:0] O_EXR  = 14'b0_0_0_0_0_0_01_00_10_0_0;
  localparam logic [13:0] O_RWB  = 14'b0_0_0_0_0_0_00_00_00_1_0;
  localparam logic [13:0] O_BRN  = 14'b0_0_0_0_0_1_01_00_01_0_0;
  localparam logic [13:0] O_BRT  = 14'b0_0_0_0_1_1_01_00_01_0_0;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [6:0]    opcode = '0;
  logic          zero = 1'b0;
  logic          mem_ready = 1'b0;
  logic          mem_req, mem_we, iord, ir_write, pc_write, pc_src;
  logic [1:0]    alu_src_a, alu_src_b, alu_op;
  logic          reg_write, mem_to_reg, illegal, bus_err;
  logic [RW-1:0] retired;
  logic [3:0]    state_o;
  logic [13:0]   outs;

  always #5 clk = ~clk;

  multicycle_control #(.RETIRE_W(RW), .TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .illegal(illegal), .bus_err(bus_err),
    .retired(retired), .state_o(state_o)
  );

  assign outs = {mem_req, mem_we, iord, ir_write, pc_write, pc_src,
                 alu_src_a, alu_src_b, alu_op, reg_write, mem_to_reg};

  typedef struct {
    logic [3:0]  st;
    logic [13:0] o;
    logic        rdy;
    logic        zr;
    logic [6:0]  opc;
    logic        ret;
    logic [1:0]  flag;   // 1: illegal trap after this cycle, 2: bus trap
  } cyc_t;

  cyc_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   ret_m   = 0;
  bit   ill_m   = 0;
  bit   bus_m   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void push(input logic [3:0] st, input logic [13:0] o, input logic rdy,
                               input logic zr, input logic [6:0] opc, input logic ret,
                               input logic [1:0] flag);
    cyc_t c;
    c.st = st; c.o = o; c.rdy = rdy; c.zr = zr; c.opc = opc; c.ret = ret; c.flag = flag;
    q.push_back(c);
  endfunction

  function automatic logic r1();
    return 1'($urandom);
  endfunction

  function automatic logic [6:0] r7();
    return 7'($urandom);
  endfunction

  function automatic bit legal(input logic [6:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_R) || (op == OP_BEQ);
  endfunction

  // Expected trace of one instruction; fw/mw are stall cycles before ready.
  task automatic plan(input logic [6:0] op, input int fw, input int mw, input logic z,
                      output bit trapped);
    logic [3:0]  mst;
    logic [13:0] mo;
    trapped = 0;
    for (int i = 0; i < fw && i < T; i++)
      push(4'd1, O_FST, 1'b0, r1(), r7(), 1'b0, (i == T-1) ? 2'd2 : 2'd0);
    if (fw >= T) begin trapped = 1; return; end
    push(4'd1, O_FDN, 1'b1, r1(), r7(), 1'b0, 2'd0);
    if (!legal(op)) begin
      push(4'd2, O_DEC, r1(), r1(), op, 1'b0, 2'd1);
      trapped = 1;
      return;
    end
    push(4'd2, O_DEC, r1(), r1(), op, 1'b0, 2'd0);
    if (op == OP_LW || op == OP_SW) begin
      push(4'd3, O_MADR, r1(), r1(), r7(), 1'b0, 2'd0);
      mst = (op == OP_LW) ? 4'd4 : 4'd6;
      mo  = (op == OP_LW) ? O_MRD : O_MWR;
      for (int i = 0; i < mw && i < T; i++)
        push(mst, mo, 1'b0, r1(), r7(), 1'b0, (i == T-1) ? 2'd2 : 2'd0);
      if (mw >= T) begin trapped = 1; return; end
      if (op == OP_LW) begin
        push(4'd4, O_MRD, 1'b1, r1(), r7(), 1'b0, 2'd0);
        push(4'd5, O_MWB, r1(), r1(), r7(), 1'b1, 2'd0);
      end else begin
        push(4'd6, O_MWR, 1'b1, r1(), r7(), 1'b1, 2'd0);
      end
    end else if (op == OP_R) begin
      push(4'd7, O_EXR, r1(), r1(), r7(), 1'b0, 2'd0);
      push(4'd8, O_RWB, r1(), r1(), r7(), 1'b1, 2'd0);
    end else begin
      push(4'd9, z ? O_BRT : O_BRN, r1(), z, r7(), 1'b1, 2'd0);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] st, input logic [13:0] o);
    chk({tag, "_state"}, 32'(state_o), 32'(st));
    chk({tag, "_outs"}, 32'(outs), 32'(o));
    chk({tag, "_retired"}, 32'(retired), 32'(ret_m));
    chk({tag, "_illegal"}, 32'(illegal), 32'(ill_m));
    chk({tag, "_bus_err"}, 32'(bus_err), 32'(bus_m));
  endtask

  // Asserts rst mid-cycle, checks the immediate clear, then the INIT cycle.
  task automatic do_reset();
    #1 rst = 1'b1;
    #1;
    ret_m = 0; ill_m = 0; bus_m = 0;
    check_all("rst", 4'd0, O_NONE);
    @(negedge clk);
    mem_ready = r1(); zero = r1(); opcode = r7();
    #1 check_all("rst_held", 4'd0, O_NONE);
    @(negedge clk);
    rst = 1'b0;
    mem_ready = r1(); zero = r1(); opcode = r7();
    #1 check_all("init", 4'd0, O_NONE);
  endtask

  task automatic run(input int abort_at, output bit aborted);
    cyc_t c;
    int   idx = 0;
    aborted = 0;
    while (q.size() > 0) begin
      c = q.pop_front();
      @(negedge clk);
      mem_ready = c.rdy; zero = c.zr; opcode = c.opc;
      #1 check_all("cyc", c.st, c.o);
      if (idx == abort_at) begin
        do_reset();
        q.delete();
        aborted = 1;
        return;
      end
      if (c.ret) ret_m = (ret_m + 1) % (1 << RW);
      if (c.flag == 2'd1) ill_m = 1;
      if (c.flag == 2'd2) bus_m = 1;
      idx++;
    end
  endtask

  // abort < -1 means: pick a random mid-instruction reset point now and then.
  task automatic instr(input logic [6:0] op, input int fw, input int mw, input logic z,
                       input int abort);
    bit t, ab;
    int a;
    plan(op, fw, mw, z, t);
    if (t) for (int i = 0; i < 3; i++) push(4'd15, O_NONE, r1(), r1(), r7(), 1'b0, 2'd0);
    a = abort;
    if (abort < -1) a = ($urandom_range(0, 11) == 0) ? $urandom_range(0, q.size() - 1) : -1;
    run(a, ab);
    if (t && !ab) do_reset();
  endtask

  initial begin
    logic [6:0] op;
    int         k, fw, mw;
    do_reset();
    instr(OP_R,   0, 0, 1'b0, -1);
    instr(OP_LW,  3, 2, 1'b0, -1);
    instr(OP_BEQ, 0, 0, 1'b1, -1);
    instr(OP_BEQ, 0, 0, 1'b0, -1);
    instr(7'h7f,  0, 0, 1'b0, -1);
    instr(OP_SW,  0, T, 1'b0, -1);
    instr(OP_SW,  0, T-1, 1'b0, -1);
    instr(OP_R,   T-1, 0, 1'b0, -1);
    instr(OP_R,   T, 0, 1'b0, -1);
    instr(OP_LW,  0, 0, 1'b0, -1);
    instr(OP_SW,  0, 9, 1'b0, 4);
    for (int n = 0; n < 90; n++) begin
      k = $urandom_range(0, 9);
      case (k)
        0, 1:    op = OP_LW;
        2, 3:    op = OP_SW;
        4, 5, 9: op = OP_R;
        6, 7:    op = OP_BEQ;
        default: begin
          op = r7();
          while (legal(op)) op = r7();
        end
      endcase
      fw = ($urandom_range(0, 11) == 0) ? T : $urandom_range(0, T-1);
      mw = ($urandom_range(0, 11) == 0) ? T : $urandom_range(0, T-1);
      instr(op, fw, mw, r1(), -2);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the multi-cycle RV32I-subset datapath: lw, sw, beq, R-type add/sub/and/or.
- Sequences fetch, decode, execute, memory and writeback over one shared ALU and one shared memory port.
- Drives alu_op into the ALU control decoder, and drives the mux selects and write enables for PC, IR and the register file.
- Holds a ready-handshake memory interface with a watchdog, plus an instruction-retire counter.

Parameters:
- RETIRE_W, 32, width of the retired-instruction counter.
- TIMEOUT, 64, maximum cycles to wait for mem_ready before trapping; 0 disables the watchdog.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- opcode  in  7  IR[6:0]; IR is held stable outside FETCH.
- zero  in  1  ALU zero flag, combinational from the current ALU operation.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request valid.
- mem_we  out  1  request is a store.
- iord  out  1  memory address select: 0=PC, 1=ALUOut.
- ir_write  out  1  load IR from memory read data.
- pc_write  out  1  load PC.
- pc_src  out  1  PC source: 0=ALU result, 1=ALUOut register.
- alu_src_a  out  2  ALU A select: 00=PC, 01=rs1, 10=oldPC.
- alu_src_b  out  2  ALU B select: 00=rs2, 01=const 4, 10=immediate.
- alu_op  out  2  00=add, 01=sub, 10=funct-decoded.
- reg_write  out  1  register file write enable.
- mem_to_reg  out  1  writeback source: 0=ALUOut, 1=MDR.
- illegal  out  1  trap taken because of an unknown opcode; sticky.
- bus_err  out  1  trap taken because of a memory timeout; sticky.
- retired  out  RETIRE_W  count of completed instructions.
- state_o  out  4  current state encoding, for debug.

Behaviour:
- Reset (asynchronous, active-high):
  - state=INIT; retired=0, illegal=0, bus_err=0, wait counter=0.
  - All control outputs are 0 while rst is high and while in INIT.
- State encodings: INIT=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_READ=4, MEM_WB=5, MEM_WRITE=6, EXEC_R=7, R_WB=8, BRANCH=9, TRAP=15.
- Outputs are decoded from state; only the enables qualified by mem_ready or zero depend on inputs. Any output not listed for a state is 0.
- INIT: go to FETCH next cycle.
- FETCH:
  - Outputs: mem_req=1, iord=0, alu_src_a=00, alu_src_b=01, alu_op=00.
  - ir_write=pc_write=mem_ready; pc_src=0.
  - Stay while mem_ready=0. When mem_ready=1, go to DECODE.
- DECODE:
  - Outputs: alu_src_a=10, alu_src_b=10, alu_op=00 (precomputes the branch target into ALUOut).
  - Latch opcode into op_q.
  - Next state by opcode:
    - 0000011 or 0100011 -> MEM_ADDR.
    - 0110011 -> EXEC_R.
    - 1100011 -> BRANCH.
    - any other value -> TRAP with illegal=1.
- MEM_ADDR: alu_src_a=01, alu_src_b=10, alu_op=00. Next is MEM_READ if op_q=lw, otherwise MEM_WRITE.
- MEM_READ: mem_req=1, iord=1. Wait for mem_ready, then go to MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1. Go to FETCH; retire.
- MEM_WRITE: mem_req=1, mem_we=1, iord=1. Wait for mem_ready, then go to FETCH; retire.
- EXEC_R: alu_src_a=01, alu_src_b=00, alu_op=10. Go to R_WB.
- R_WB: reg_write=1, mem_to_reg=0. Go to FETCH; retire.
- BRANCH:
  - Outputs: alu_src_a=01, alu_src_b=00, alu_op=01, pc_src=1, pc_write=zero.
  - Go to FETCH; retire whether or not the branch is taken.
- TRAP: all enables 0; stays in TRAP until reset. The illegal and bus_err flags are never cleared except by reset.
- Retire:
  - retired increments by 1 on the exit edge of MEM_WB, MEM_WRITE(ready), R_WB and BRANCH.
  - Wraps modulo 2^RETIRE_W.
- Latency with zero memory wait states:
  - R-type: 4 cycles.
  - beq: 3 cycles.
  - sw: 4 cycles.
  - lw: 5 cycles.
- Watchdog:
  - Wait counter counts consecutive cycles in FETCH, MEM_READ or MEM_WRITE with mem_ready=0.
  - Counter is cleared on mem_ready or on any state change.
  - If TIMEOUT>0 and the counter reaches TIMEOUT with mem_ready still 0, go to TRAP with bus_err=1 on the next edge.
  - mem_ready=1 in the same cycle as the counter reaching TIMEOUT wins: the access completes and there is no trap.
- mem_req stays asserted and its address select held stable until mem_ready. mem_ready outside FETCH/MEM_READ/MEM_WRITE is ignored.
- opcode changes outside DECODE do not affect sequencing.
- Reset mid-instruction returns to INIT immediately; no partial retire, and no write enable is asserted.

Test Plan:
- Reset, then R-type opcode 0110011 with mem_ready held 1 -> states 1,2,7,8,1; reg_write=1 only in R_WB; alu_op=10 in EXEC_R; retired=1 after 4 cycles.
- lw (0000011) with 3 wait cycles in FETCH and 2 in MEM_READ -> mem_req held with iord=0 then iord=1; ir_write pulses exactly once; mem_to_reg=1 in MEM_WB; total 10 cycles.
- beq with zero=1, then beq with zero=0 -> pc_write=1, pc_src=1 in the first BRANCH only; retired=2 after both.
- Opcode 1111111 in DECODE -> TRAP (state_o=15), illegal=1; further mem_ready or opcode input produces no output change; rst clears illegal.
- TIMEOUT=4, sw with mem_ready held 0 -> bus_err=1 and TRAP after 4 stalled MEM_WRITE cycles. Repeat with mem_ready=1 on the 4th stalled cycle -> no trap, retire.
- rst asserted asynchronously mid-MEM_WRITE -> all outputs 0 immediately, retired unchanged from its prior value then reset to 0; FETCH resumes one cycle after rst deasserts.
